// File: rtl/mdio_pkg.sv
// Shared types and constants for the Clause-22 MDIO PHY responder.
package mdio_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ST,
    OP,
    PHYAD,
    REGAD,
    TA,
    DATA,
    SKIP
  } mdio_state_e;

  localparam logic [1:0] MDIO_OP_RD  = 2'b10;
  localparam logic [1:0] MDIO_OP_WR  = 2'b01;
  localparam int         MDIO_DATA_W = 16;

endpackage

// File: rtl/mdio_regfile.sv
// Per-PHY register storage: backdoor and frame write ports (backdoor wins on
// collision, frame port honours RO_MASK), two combinational read ports.
module mdio_regfile
  import mdio_pkg::*;
#(
  parameter int          NUM_PHY  = 1,
  parameter int          NUM_REGS = 32,
  parameter logic [31:0] RO_MASK  = 32'h0000_000C
) (
  input  logic                   clk_i,
  input  logic                   rstn_i,
  input  logic                   bd_we_i,
  input  logic [2:0]             bd_phy_i,
  input  logic [4:0]             bd_addr_i,
  input  logic [MDIO_DATA_W-1:0] bd_wdata_i,
  output logic [MDIO_DATA_W-1:0] bd_rdata_o,
  input  logic                   fr_we_i,
  input  logic [2:0]             fr_phy_i,
  input  logic [4:0]             fr_addr_i,
  input  logic [MDIO_DATA_W-1:0] fr_wdata_i,
  input  logic [2:0]             rd_phy_i,
  input  logic [4:0]             rd_addr_i,
  output logic [MDIO_DATA_W-1:0] rd_data_o
);

  logic [MDIO_DATA_W-1:0] r_mem [NUM_PHY][NUM_REGS];

  // Storage update: reset pattern {phy, reg}, backdoor before frame writes
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      for (int unsigned p = 0; p < NUM_PHY; p++)
        for (int unsigned r = 0; r < NUM_REGS; r++)
          r_mem[p][r] <= {8'(p), 8'(r)};
    end else begin
      for (int unsigned p = 0; p < NUM_PHY; p++) begin
        for (int unsigned r = 0; r < NUM_REGS; r++) begin
          if (bd_we_i && bd_phy_i == 3'(p) && bd_addr_i == 5'(r))
            r_mem[p][r] <= bd_wdata_i;
          else if (fr_we_i && !RO_MASK[r] && fr_phy_i == 3'(p) && fr_addr_i == 5'(r))
            r_mem[p][r] <= fr_wdata_i;
        end
      end
    end
  end

  // Backdoor read; unimplemented locations read as all ones
  always_comb begin
    bd_rdata_o = '1;
    for (int unsigned p = 0; p < NUM_PHY; p++)
      for (int unsigned r = 0; r < NUM_REGS; r++)
        if (bd_phy_i == 3'(p) && bd_addr_i == 5'(r))
          bd_rdata_o = r_mem[p][r];
  end

  // Frame-side read used for the REGAD snapshot
  always_comb begin
    rd_data_o = '1;
    for (int unsigned p = 0; p < NUM_PHY; p++)
      for (int unsigned r = 0; r < NUM_REGS; r++)
        if (rd_phy_i == 3'(p) && rd_addr_i == 5'(r))
          rd_data_o = r_mem[p][r];
  end

endmodule

// File: rtl/mdio_phy_responder.sv
// Clause-22 MDIO PHY responder: MDC/MDIO synchronisers, edge detect, frame
// FSM, shift registers and a per-PHY register file with backdoor access.
module mdio_phy_responder
  import mdio_pkg::*;
#(
  parameter int          NUM_PHY       = 1,
  parameter logic [4:0]  PHY_ADDR_BASE = 5'd1,
  parameter int          NUM_REGS      = 32,
  parameter int          PREAMBLE_MIN  = 32,
  parameter logic [31:0] RO_MASK       = 32'h0000_000C
) (
  input  logic        clk_i,
  input  logic        rstn_i,
  input  logic        mdc_i,
  input  logic        mdio_i,
  output logic        mdio_o,
  output logic        mdio_oe_o,
  input  logic        bd_we_i,
  input  logic [2:0]  bd_phy_i,
  input  logic [4:0]  bd_addr_i,
  input  logic [15:0] bd_wdata_i,
  output logic [15:0] bd_rdata_o,
  output logic        frame_done_o,
  output logic        frame_wr_o,
  output logic        frame_err_o
);

  localparam int                PCW      = $clog2(PREAMBLE_MIN + 1);
  localparam logic [PCW-1:0]    PRE_FULL = PCW'(PREAMBLE_MIN);
  localparam logic [5:0]        ADDR_LO  = {1'b0, PHY_ADDR_BASE};
  localparam logic [5:0]        ADDR_HI  = ADDR_LO + 6'(NUM_PHY);

  logic r_mdc_s1, r_mdc_s2, r_mdc_d;
  logic r_mdio_s1, r_mdio_s2;
  logic w_rise, w_fall, w_bit;

  mdio_state_e            r_state, w_state_nxt;
  logic [PCW-1:0]         r_pre_cnt, w_pre_nxt;
  logic [4:0]             r_cnt, w_cnt_nxt;
  logic [1:0]             r_op, w_op_nxt;
  logic [4:0]             r_phyad, w_phyad_nxt;
  logic [4:0]             r_regad, w_regad_nxt;
  logic [2:0]             r_phy_idx, w_phy_idx_nxt;
  logic [MDIO_DATA_W-1:0] r_shift, w_shift_nxt;
  logic                   r_oe, w_oe_nxt;
  logic                   r_mdo, w_mdo_nxt;
  logic                   r_done, w_done_nxt;
  logic                   r_wr, w_wr_nxt;
  logic                   r_err, w_err_nxt;

  logic                   w_hit;
  logic [2:0]             w_snap_idx;
  logic [4:0]             w_regad_full;
  logic [MDIO_DATA_W-1:0] w_snap_data;
  logic [MDIO_DATA_W-1:0] w_fr_wdata;
  logic                   w_fr_we;
  logic                   w_reg_locked;

  // Two-flop synchronisers plus delayed MDC for edge detection
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_mdc_s1  <= 1'b0;
      r_mdc_s2  <= 1'b0;
      r_mdc_d   <= 1'b0;
      r_mdio_s1 <= 1'b1;
      r_mdio_s2 <= 1'b1;
    end else begin
      r_mdc_s1  <= mdc_i;
      r_mdc_s2  <= r_mdc_s1;
      r_mdc_d   <= r_mdc_s2;
      r_mdio_s1 <= mdio_i;
      r_mdio_s2 <= r_mdio_s1;
    end
  end

  assign w_rise = r_mdc_s2 & ~r_mdc_d;
  assign w_fall = ~r_mdc_s2 & r_mdc_d;
  assign w_bit  = r_mdio_s2;

  assign w_hit        = ({1'b0, r_phyad} >= ADDR_LO) && ({1'b0, r_phyad} < ADDR_HI);
  assign w_snap_idx   = 3'(r_phyad - PHY_ADDR_BASE);
  assign w_regad_full = {r_regad[3:0], w_bit};
  assign w_fr_wdata   = {r_shift[MDIO_DATA_W-2:0], w_bit};
  assign w_reg_locked = RO_MASK[r_regad] || (32'(r_regad) >= 32'(NUM_REGS));

  // FSM and datapath registers
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_state   <= IDLE;
      r_pre_cnt <= '0;
      r_cnt     <= '0;
      r_op      <= '0;
      r_phyad   <= '0;
      r_regad   <= '0;
      r_phy_idx <= '0;
      r_shift   <= '0;
      r_oe      <= 1'b0;
      r_mdo     <= 1'b1;
      r_done    <= 1'b0;
      r_wr      <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_pre_cnt <= w_pre_nxt;
      r_cnt     <= w_cnt_nxt;
      r_op      <= w_op_nxt;
      r_phyad   <= w_phyad_nxt;
      r_regad   <= w_regad_nxt;
      r_phy_idx <= w_phy_idx_nxt;
      r_shift   <= w_shift_nxt;
      r_oe      <= w_oe_nxt;
      r_mdo     <= w_mdo_nxt;
      r_done    <= w_done_nxt;
      r_wr      <= w_wr_nxt;
      r_err     <= w_err_nxt;
    end
  end

  // Next-state: frame decode on MDC rise, pad drive on MDC fall
  always_comb begin
    w_state_nxt   = r_state;
    w_pre_nxt     = r_pre_cnt;
    w_cnt_nxt     = r_cnt;
    w_op_nxt      = r_op;
    w_phyad_nxt   = r_phyad;
    w_regad_nxt   = r_regad;
    w_phy_idx_nxt = r_phy_idx;
    w_shift_nxt   = r_shift;
    w_oe_nxt      = r_oe;
    w_mdo_nxt     = r_mdo;
    w_done_nxt    = 1'b0;
    w_wr_nxt      = r_wr;
    w_err_nxt     = 1'b0;
    w_fr_we       = 1'b0;

    if (w_rise) begin
      case (r_state)
        IDLE: begin
          if (w_bit) begin
            if (r_pre_cnt < PRE_FULL) w_pre_nxt = r_pre_cnt + 1'b1;
          end else begin
            if (r_pre_cnt == PRE_FULL) w_state_nxt = ST;
            w_pre_nxt = '0;
          end
        end
        ST: begin
          w_cnt_nxt = '0;
          if (w_bit) begin
            w_state_nxt = OP;
          end else begin
            w_err_nxt   = 1'b1;
            w_state_nxt = IDLE;
          end
        end
        OP: begin
          w_op_nxt = {r_op[0], w_bit};
          if (r_cnt == 5'd1) begin
            w_cnt_nxt = '0;
            if ({r_op[0], w_bit} == MDIO_OP_RD || {r_op[0], w_bit} == MDIO_OP_WR) begin
              w_state_nxt = PHYAD;
            end else begin
              w_err_nxt   = 1'b1;
              w_state_nxt = IDLE;
            end
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
        PHYAD: begin
          w_phyad_nxt = {r_phyad[3:0], w_bit};
          if (r_cnt == 5'd4) begin
            w_cnt_nxt   = '0;
            w_state_nxt = REGAD;
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
        REGAD: begin
          w_regad_nxt = w_regad_full;
          if (r_cnt == 5'd4) begin
            w_cnt_nxt = '0;
            if (w_hit) begin
              w_phy_idx_nxt = w_snap_idx;
              w_shift_nxt   = w_snap_data;
              w_state_nxt   = TA;
            end else begin
              w_state_nxt = SKIP;
            end
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
        TA: begin
          if (r_cnt == 5'd1) begin
            w_cnt_nxt   = '0;
            w_state_nxt = DATA;
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
        DATA: begin
          if (r_op == MDIO_OP_WR) w_shift_nxt = w_fr_wdata;
          if (r_cnt == 5'd15) begin
            w_done_nxt  = 1'b1;
            w_wr_nxt    = (r_op == MDIO_OP_WR);
            w_cnt_nxt   = '0;
            w_pre_nxt   = '0;
            w_state_nxt = IDLE;
            if (r_op == MDIO_OP_WR) begin
              w_fr_we   = 1'b1;
              w_err_nxt = w_reg_locked;
            end
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
        SKIP: begin
          if (r_cnt == 5'd17) begin
            w_cnt_nxt   = '0;
            w_pre_nxt   = '0;
            w_state_nxt = IDLE;
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
        default: begin
          w_state_nxt = IDLE;
          w_pre_nxt   = '0;
        end
      endcase
    end else if (w_fall) begin
      // Read data is pre-loaded at REGAD and shifted out on falls; the fall
      // following the last data rise lands in IDLE and releases the pad.
      if (r_state == DATA && r_op == MDIO_OP_RD) begin
        w_mdo_nxt   = r_shift[MDIO_DATA_W-1];
        w_shift_nxt = {r_shift[MDIO_DATA_W-2:0], 1'b0};
      end else if (r_state == TA && r_cnt == 5'd1 && r_op == MDIO_OP_RD) begin
        w_oe_nxt  = 1'b1;
        w_mdo_nxt = 1'b0;
      end else begin
        w_oe_nxt  = 1'b0;
        w_mdo_nxt = 1'b1;
      end
    end
  end

  mdio_regfile #(
    .NUM_PHY  (NUM_PHY),
    .NUM_REGS (NUM_REGS),
    .RO_MASK  (RO_MASK)
  ) u_regfile (
    .clk_i      (clk_i),
    .rstn_i     (rstn_i),
    .bd_we_i    (bd_we_i),
    .bd_phy_i   (bd_phy_i),
    .bd_addr_i  (bd_addr_i),
    .bd_wdata_i (bd_wdata_i),
    .bd_rdata_o (bd_rdata_o),
    .fr_we_i    (w_fr_we),
    .fr_phy_i   (r_phy_idx),
    .fr_addr_i  (r_regad),
    .fr_wdata_i (w_fr_wdata),
    .rd_phy_i   (w_snap_idx),
    .rd_addr_i  (w_regad_full),
    .rd_data_o  (w_snap_data)
  );

  assign mdio_o       = r_mdo;
  assign mdio_oe_o    = r_oe;
  assign frame_done_o = r_done;
  assign frame_wr_o   = r_wr;
  assign frame_err_o  = r_err;

endmodule
